// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder:
//   - byte-lane geometry (BYTE_W, LANES, WORD_W)
//   - trace record layout (packed struct plus explicit field offsets, 100 bits)
//   - merge_lane(): selects the store byte or the existing RAM byte for one lane
// -----------------------------------------------------------------------------
package dm_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = BYTE_W * LANES;

    // Trace record, MSB first: {pc, addr, data, byteen}.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic [LANES-1:0]  byteen;
    } trace_rec_t;

    localparam int TRC_BYTEEN_LSB = 0;
    localparam int TRC_DATA_LSB   = TRC_BYTEEN_LSB + LANES;
    localparam int TRC_ADDR_LSB   = TRC_DATA_LSB + WORD_W;
    localparam int TRC_PC_LSB     = TRC_ADDR_LSB + WORD_W;
    localparam int TRC_W          = TRC_PC_LSB + WORD_W;

    // One lane of a byte-enabled store: the new byte when enabled, else the old.
    function automatic logic [BYTE_W-1:0] merge_lane(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/dm_trace_fifo.sv
// -----------------------------------------------------------------------------
// dm_trace_fifo
// Show-ahead FIFO holding store-trace records, with a saturating drop counter.
// Ports:
//   clk, reset       clock; asynchronous active-low reset
//   push, push_data  enqueue request and record
//   pop_ready        consumer accepts the head (pop = valid && pop_ready)
//   valid, head      head record, meaningful while valid = 1
//   full, empty      occupancy flags
//   ovf_cnt          records dropped because the FIFO was full and not popping
// Parameters: WIDTH record width, DEPTH entries (power of two, >= 2).
// -----------------------------------------------------------------------------
module dm_trace_fifo #(
    parameter int WIDTH = 100,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [15:0]      ovf_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] fifo_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [15:0]      ovf_q,    ovf_d;

    logic pop;
    logic push_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign valid   = !empty;
    assign head    = fifo_mem[rd_ptr_q];
    assign ovf_cnt = ovf_q;

    assign pop     = valid && pop_ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push_ok = push && (!full || pop);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push && !push_ok && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking <= so every flop samples
        // pre-edge values regardless of statement order.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: storage arrays carry no reset; the count already marks stale
    // entries invalid, and a reset-free array maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// Data-memory responder behind the CPU M-stage data port. Word-organised RAM
// with byte-lane writes, combinational read, and a trace FIFO of every
// accepted store.
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   m_data_addr/wdata/byteen   CPU data port (byteen = 0 is a read or idle)
//   m_inst_addr                PC of the M-stage instruction, traced
//   m_data_rdata               word at m_data_addr, same cycle
//   trc_valid/ready            show-ahead trace handshake
//   trc_pc/addr/data/byteen    head trace record (data is the merged word)
//   trc_ovf_cnt                saturating count of dropped trace records
//   err_oor                    sticky out-of-range flag
// Configuration macro: DM_OOR_ERR_EN
//   defined   -> out-of-range accesses set err_oor; such writes are dropped
//   undefined -> addresses wrap into the RAM and err_oor is tied low
// -----------------------------------------------------------------------------
module dm_responder
    import dm_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] BASE       = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [31:0] trc_pc,
    output logic [31:0] trc_addr,
    output logic [31:0] trc_data,
    output logic [3:0]  trc_byteen,
    output logic [15:0] trc_ovf_cnt,
    output logic        err_oor
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    logic [31:0]       offset;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic [WORD_W-1:0] old_word;
    logic [WORD_W-1:0] merged_word;
    logic              wr_en;
    trace_rec_t        push_rec;
    logic [TRC_W-1:0]  fifo_head;
    logic              unused_addr_bits;
    logic              unused_fifo_full;
    logic              unused_fifo_empty;

    assign offset = m_data_addr - BASE;
    assign idx    = offset[ADDR_W+1:2];

`ifdef DM_OOR_ERR_EN
    assign in_range = (offset[31:ADDR_W+2] == '0);
`else
    assign in_range = 1'b1;
`endif

    // Byte offset and (in the wrapping build) the high offset bits do not
    // select anything.
    assign unused_addr_bits = ^{offset[31:ADDR_W+2], offset[1:0]};

    assign old_word     = mem[idx];
    assign m_data_rdata = (reset && in_range) ? old_word : '0;

    always_comb begin
        merged_word = '0;
        for (int l = 0; l < LANES; l++) begin
            merged_word[l*BYTE_W +: BYTE_W] = merge_lane(old_word[l*BYTE_W +: BYTE_W],
                                                         m_data_wdata[l*BYTE_W +: BYTE_W],
                                                         m_data_byteen[l]);
        end
    end

    // Qualifying with reset discards a store that coincides with reset.
    assign wr_en = reset && in_range && (m_data_byteen != '0);

    // Written word appears on the read port from the next cycle only.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= merged_word;
    end

    always_comb begin
        push_rec        = '0;
        push_rec.pc     = m_inst_addr;
        push_rec.addr   = BASE + 32'({idx, 2'b00});
        push_rec.data   = merged_word;
        push_rec.byteen = m_data_byteen;
    end

    dm_trace_fifo #(
        .WIDTH (TRC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (push_rec),
        .pop_ready (trc_ready),
        .valid     (trc_valid),
        .head      (fifo_head),
        .full      (unused_fifo_full),
        .empty     (unused_fifo_empty),
        .ovf_cnt   (trc_ovf_cnt)
    );

    assign trc_pc     = fifo_head[TRC_PC_LSB     +: WORD_W];
    assign trc_addr   = fifo_head[TRC_ADDR_LSB   +: WORD_W];
    assign trc_data   = fifo_head[TRC_DATA_LSB   +: WORD_W];
    assign trc_byteen = fifo_head[TRC_BYTEEN_LSB +: LANES];

`ifdef DM_OOR_ERR_EN
    logic err_oor_q, err_oor_d;

    // Any out-of-range address seen while out of reset latches the flag.
    assign err_oor_d = err_oor_q || !in_range;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_oor_q <= 1'b0;
        else        err_oor_q <= err_oor_d;
    end

    assign err_oor = err_oor_q;
`else
    assign err_oor = 1'b0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
// Directed bench for dm_responder (ADDR_W = 4, BASE = 0, FIFO_DEPTH = 8).
// A word-level RAM model and a queue of expected trace records are updated as
// stores are driven; trace records are popped and compared as the DUT
// presents them. Handles both builds of DM_OOR_ERR_EN.
// -----------------------------------------------------------------------------
module tb_dm_responder;

    localparam int DEPTH  = 8;
    localparam int NWORDS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        trc_valid;
    logic        trc_ready;
    logic [31:0] trc_pc;
    logic [31:0] trc_addr;
    logic [31:0] trc_data;
    logic [3:0]  trc_byteen;
    logic [15:0] trc_ovf_cnt;
    logic        err_oor;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [NWORDS];
    logic [99:0] sb [$];
    int          ovf_model = 0;

    always #5 clk = ~clk;

    dm_responder #(
        .ADDR_W     (4),
        .BASE       (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .trc_valid     (trc_valid),
        .trc_ready     (trc_ready),
        .trc_pc        (trc_pc),
        .trc_addr      (trc_addr),
        .trc_data      (trc_data),
        .trc_byteen    (trc_byteen),
        .trc_ovf_cnt   (trc_ovf_cnt),
        .err_oor       (err_oor)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [99:0] head_rec();
        return {trc_pc, trc_addr, trc_data, trc_byteen};
    endfunction

    // One store; optionally pops the head in the same cycle and checks that
    // the read port still shows the old word during the write cycle.
    task automatic store(input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         input bit pop_same, input bit chk_old, input string tag);
        int          idx;
        bit          hit;
        logic [31:0] new_w;
        logic [99:0] exp_head;
        idx = int'(addr >> 2);
`ifdef DM_OOR_ERR_EN
        hit = (idx < NWORDS);
`else
        hit = 1'b1;
        idx = idx % NWORDS;
`endif
        @(negedge clk);
        m_inst_addr   = pc;
        m_data_addr   = addr;
        m_data_wdata  = data;
        m_data_byteen = be;
        trc_ready     = pop_same;
        #1;
        if (chk_old && hit) check({tag, "_old_rdata"}, m_data_rdata, model_mem[idx]);
        if (pop_same) begin
            exp_head = sb.pop_front();
            check({tag, "_pop_valid"}, trc_valid, 1'b1);
            check({tag, "_pop_head"}, head_rec(), exp_head);
        end
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
        m_data_addr   = 32'h10;
        trc_ready     = 1'b0;
        if (hit) begin
            new_w = model_mem[idx];
            for (int l = 0; l < 4; l++)
                if (be[l]) new_w[l*8 +: 8] = data[l*8 +: 8];
            model_mem[idx] = new_w;
            if (sb.size() < DEPTH) sb.push_back({pc, 32'(idx * 4), new_w, be});
            else if (ovf_model < 65535) ovf_model++;
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        m_data_addr   = addr;
        m_data_byteen = 4'h0;
        #1;
        check(tag, m_data_rdata, exp);
    endtask

    // Pop every expected record in order, then confirm the FIFO is empty.
    task automatic drain(input string tag);
        logic [99:0] exp_rec;
        while (sb.size() > 0) begin
            exp_rec = sb.pop_front();
            check({tag, "_valid"}, trc_valid, 1'b1);
            check({tag, "_rec"}, head_rec(), exp_rec);
            @(negedge clk);
            trc_ready = 1'b1;
            @(posedge clk);
            #1;
            trc_ready = 1'b0;
        end
        check({tag, "_empty"}, trc_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        m_data_addr   = 32'h10;
        m_data_wdata  = '0;
        m_data_byteen = 4'h0;
        m_inst_addr   = '0;
        trc_ready     = 1'b0;

        // Reset state
        #2;
        check("rst_valid", trc_valid, 1'b0);
        check("rst_ovf", trc_ovf_cnt, 16'h0);
        check("rst_err", err_oor, 1'b0);
        check("rst_rdata", m_data_rdata, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Word store, read back next cycle, trace record
        store(32'h0000_0100, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, "word");
        check("word_valid_next", trc_valid, 1'b1);
        rd(32'h10, 32'hDEAD_BEEF, "word_rd");
        drain("word_trc");

        // Byte merge with same-cycle old-value read
        store(32'h0000_0104, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b0, "pre");
        store(32'h0000_0108, 32'h20, 32'h00AA_0000, 4'b0100, 1'b0, 1'b1, "merge");
        rd(32'h20, 32'h11AA_3344, "merge_rd");
        drain("merge_trc");

        // Overflow: 10 stores with no consumer
        for (int i = 0; i < 10; i++)
            store(32'h200 + 32'(i * 4), 32'h24 + 32'((i % 6) * 4),
                  32'hA500_0000 + 32'(i), 4'hF, 1'b0, 1'b0, "ovf");
        check("ovf_cnt", trc_ovf_cnt, 16'(ovf_model));
        check("ovf_full_valid", trc_valid, 1'b1);
        // Full with simultaneous push and pop: nothing dropped
        store(32'h0000_0300, 32'h38, 32'h5A5A_A5A5, 4'hF, 1'b1, 1'b0, "fullpp");
        check("fullpp_ovf", trc_ovf_cnt, 16'(ovf_model));
        drain("ovf_trc");
        check("ovf_after_drain", trc_ovf_cnt, 16'(ovf_model));

        // Async reset mid-traffic
        store(32'h0000_0400, 32'h3C, 32'h0F0F_0F0F, 4'hF, 1'b0, 1'b0, "pre_rst");
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", trc_valid, 1'b0);
        check("arst_ovf", trc_ovf_cnt, 16'h0);
        check("arst_err", err_oor, 1'b0);
        sb.delete();
        ovf_model = 0;
        @(negedge clk);
        m_data_addr   = 32'h10;
        m_data_wdata  = 32'h5555_5555;
        m_data_byteen = 4'hF;
        #1;
        check("arst_rdata_zero", m_data_rdata, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        m_data_byteen = 4'h0;
        reset         = 1'b1;
        #1;
        check("arst_valid_after", trc_valid, 1'b0);
        rd(32'h10, 32'hDEAD_BEEF, "arst_ram_kept");

        // Out-of-range / wrapping store
        store(32'h0000_0500, 32'h00, 32'h0BAD_C0DE, 4'hF, 1'b0, 1'b0, "w0");
        drain("w0_trc");
        store(32'h0000_0504, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, "oor");
`ifdef DM_OOR_ERR_EN
        check("oor_err_set", err_oor, 1'b1);
        check("oor_no_trace", trc_valid, 1'b0);
        rd(32'h00, model_mem[0], "oor_ram_unchanged");
        @(posedge clk);
        #1;
        check("oor_err_sticky", err_oor, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("oor_err_cleared", err_oor, 1'b0);
        reset = 1'b1;
`else
        check("wrap_err_low", err_oor, 1'b0);
        rd(32'h00, 32'hCAFE_F00D, "wrap_rd");
        drain("wrap_trc");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
